// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game state encoding shared by the state FSM and its event producer
`timescale 1ns/1ps
package game_pkg;

    // 2-bit state encoding driven by the game-state FSM; 2'b11 is unused.
    typedef enum logic [1:0] {
        GAME_INITIAL = 2'b00,
        GAME_RUNNING = 2'b01,
        GAME_OVER    = 2'b10
    } game_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise and debounce one raw button, emit a press pulse
//
// Ports:
//  clk    in   system clock
//  rst_n  in   asynchronous active-low reset
//  raw    in   asynchronous active-high button input
//  level  out  debounced button level
//  press  out  one-cycle pulse on the rising edge of level
`timescale 1ns/1ps
module btn_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            // Any cycle where the synced input agrees with the accepted level
            // restarts the count, so only an unbroken run can flip the level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/game_event_ctrl.sv
// rtl/game_event_ctrl.sv - buttons and hit events to start/restart/over controls for the game FSM
//
// Ports:
//  clk          in   system clock
//  rst_n        in   asynchronous active-low reset
//  btn_start    in   raw start button
//  btn_restart  in   raw restart button
//  hit          in   one-cycle collision pulse
//  state        in   current game state from the FSM
//  start        out  one-cycle start request
//  restart      out  one-cycle restart request
//  over         out  lives exhausted
//  lives        out  remaining lives
//  invuln       out  post-hit invulnerability window active
`timescale 1ns/1ps
module game_event_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int INVULN_CYCLES   = 50_000_000,
    parameter int LIVES_INIT      = 3,
    parameter int LIVES_W         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_restart,
    input  logic               hit,
    input  logic [1:0]         state,
    output logic               start,
    output logic               restart,
    output logic               over,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln
);

    localparam int TW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

    logic          start_press;
    logic          restart_press;
    logic          start_level;
    logic          restart_level;
    logic [TW-1:0] timer;
    logic          hit_ok;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_start),
        .level (start_level),
        .press (start_press)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_restart (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_restart),
        .level (restart_level),
        .press (restart_press)
    );

    // Levels are only needed internally by the debouncers.
    logic unused_levels;
    assign unused_levels = start_level ^ restart_level;

    // A hit counts only while running, outside the invulnerability window
    // and with lives left.
    assign hit_ok = (state == GAME_RUNNING) && hit && (timer == '0) && (lives != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start   <= 1'b0;
            restart <= 1'b0;
            over    <= 1'b0;
            lives   <= LIVES_W'(LIVES_INIT);
            timer   <= '0;
        end else begin
            // Illegal state 2'b11 falls in with OVER: restart allowed, no start.
            restart <= restart_press && (state != GAME_INITIAL);
            start   <= start_press && (state == GAME_INITIAL) && !restart_press;

            if (state == GAME_INITIAL) begin
                lives <= LIVES_W'(LIVES_INIT);
                over  <= 1'b0;
                timer <= '0;
            end else if (hit_ok) begin
                lives <= lives - LIVES_W'(1);
                timer <= TW'(INVULN_CYCLES - 1);
                if (lives == LIVES_W'(1)) begin
                    over <= 1'b1;
                end
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    assign invuln = (timer != '0);

endmodule

// File: tb/tb_game_event_ctrl.sv
// tb/tb_game_event_ctrl.sv - self-checking bench for game_event_ctrl
`timescale 1ns/1ps
module tb_game_event_ctrl;

    localparam int DEB = 4;
    localparam int INV = 8;
    localparam int LIV = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start;
    logic       btn_restart;
    logic       hit;
    logic [1:0] state;
    logic       start;
    logic       restart;
    logic       over;
    logic [1:0] lives;
    logic       invuln;

    int n_chk = 0;
    int n_fail = 0;

    game_event_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .INVULN_CYCLES   (INV),
        .LIVES_INIT      (LIV),
        .LIVES_W         (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .btn_restart (btn_restart),
        .hit         (hit),
        .state       (state),
        .start       (start),
        .restart     (restart),
        .over        (over),
        .lives       (lives),
        .invuln      (invuln)
    );

    always #5 clk = ~clk;

    // Reference model: edge count, raw button history, accepted levels,
    // lives and the edge index at which invulnerability expires.
    int   cyc;
    int   hist_s[$];
    int   hist_r[$];
    int   lvl_s, lvl_r, rise_s, rise_r;
    int   m_lives, m_over, m_start, m_restart, inv_end;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_s.delete();
        hist_r.delete();
        for (int i = 0; i < 6; i++) begin
            hist_s.push_back(0);
            hist_r.push_back(0);
        end
        cyc = 0; lvl_s = 0; lvl_r = 0; rise_s = 0; rise_r = 0;
        m_lives = LIV; m_over = 0; m_start = 0; m_restart = 0; inv_end = 0;
    endtask

    // A level is accepted once the synchronised input (raw delayed two
    // edges) has disagreed with it on DEB consecutive edges.
    function automatic int flips(ref int h[$], input int lvl);
        int n = h.size();
        for (int j = 0; j < DEB; j++)
            if (h[n - 3 - j] == lvl) return 0;
        return 1;
    endfunction

    task automatic model_edge();
        int prev;
        m_start   = (rise_s && state == 2'b00 && !rise_r) ? 1 : 0;
        m_restart = (rise_r && state != 2'b00) ? 1 : 0;
        if (state == 2'b00) begin
            m_lives = LIV; m_over = 0; inv_end = 0;
        end else if (state == 2'b01 && hit && cyc >= inv_end && m_lives != 0) begin
            m_lives = m_lives - 1;
            inv_end = cyc + INV;
            if (m_lives == 0) m_over = 1;
        end
        hist_s.push_back(int'(btn_start));
        hist_r.push_back(int'(btn_restart));
        if (hist_s.size() > 12) begin
            void'(hist_s.pop_front());
            void'(hist_r.pop_front());
        end
        prev = lvl_s;
        if (flips(hist_s, lvl_s)) lvl_s = 1 - lvl_s;
        rise_s = (lvl_s && !prev) ? 1 : 0;
        prev = lvl_r;
        if (flips(hist_r, lvl_r)) lvl_r = 1 - lvl_r;
        rise_r = (lvl_r && !prev) ? 1 : 0;
        cyc++;
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ".start"},   int'(start),   m_start);
        chk({ph, ".restart"}, int'(restart), m_restart);
        chk({ph, ".over"},    int'(over),    m_over);
        chk({ph, ".lives"},   int'(lives),   m_lives);
        chk({ph, ".invuln"},  int'(invuln),  (cyc < inv_end) ? 1 : 0);
    endtask

    // One clock edge: model follows the inputs present at the edge, then
    // outputs are sampled 1 ns later.
    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic pulse_hit(input string ph);
        hit = 1'b1;
        step(ph);
        hit = 1'b0;
    endtask

    int pulses;
    int pulse_at;

    initial begin
        rst_n = 1'b0; btn_start = 1'b0; btn_restart = 1'b0; hit = 1'b0; state = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset.lives_const", int'(lives), 3);
        rst_n = 1'b1;

        // 1: short glitch on start never produces a pulse
        btn_start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step("glitch"); pulses += int'(start); end
        btn_start = 1'b0;
        for (int i = 0; i < 12; i++) begin step("glitch"); pulses += int'(start); end
        chk("glitch.pulses", pulses, 0);

        // 2: long press gives exactly one pulse, 7 cycles after the edge
        btn_start = 1'b1;
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step("hold");
            if (start) begin pulses++; pulse_at = i; end
        end
        btn_start = 1'b0;
        for (int i = 0; i < 10; i++) step("hold_rel");
        chk("hold.pulses", pulses, 1);
        chk("hold.latency", pulse_at, 7);

        // 3: three spaced hits drain all lives
        state = 2'b01;
        step("run");
        for (int k = 0; k < 3; k++) begin
            pulse_hit("hits3");
            chk("hits3.lives", int'(lives), 2 - k);
            chk("hits3.invuln", int'(invuln), 1);
            for (int i = 0; i < 9; i++) step("hits3");
        end
        chk("hits3.over", int'(over), 1);
        pulse_hit("hits3_extra");
        chk("hits3.floor", int'(lives), 0);

        // 5: both buttons at once while running -> restart only, then back to INITIAL
        btn_start = 1'b1; btn_restart = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin step("both"); pulses += int'(restart); end
        btn_start = 1'b0; btn_restart = 1'b0;
        for (int i = 0; i < 8; i++) step("both_rel");
        chk("both.restart_pulses", pulses, 1);
        state = 2'b00;
        step("back_init");
        chk("back_init.lives", int'(lives), 3);
        chk("back_init.over", int'(over), 0);

        // 4: hit inside the invulnerability window is ignored
        state = 2'b01;
        pulse_hit("hits_close");
        step("hits_close"); step("hits_close");
        pulse_hit("hits_close");
        for (int i = 0; i < 10; i++) step("hits_close");
        chk("hits_close.lives", int'(lives), 2);

        // 6: async reset mid-game with lives=1 and invuln active
        pulse_hit("pre_reset");
        chk("pre_reset.lives", int'(lives), 1);
        chk("pre_reset.invuln", int'(invuln), 1);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk("async.lives", int'(lives), 3);
        chk("async.invuln", int'(invuln), 0);
        chk("async.over", int'(over), 0);
        chk("async.start", int'(start), 0);
        #0.5;
        rst_n = 1'b1;
        model_reset();

        // Random phase: slow-changing buttons and state, frequent hits
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 11) == 0) btn_restart = ~btn_restart;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: state = 2'b00;
                    3:       state = 2'b10;
                    4:       state = 2'b11;
                    default: state = 2'b01;
                endcase
            end
            hit = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
